// File: rtl/z80_irq_ctrl.sv
// Interrupt front-end for the TV80: NMI synchronizer/edge latch, prioritized INT with IM2 vector.
// Define Z80_IRQ_RETI_EN to build the RETI opcode snoop and the in-service nesting register.
module z80_irq_ctrl #(
  parameter int         NSRC     = 4,
  parameter logic [7:0] VEC_BASE = 8'hE0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            nmi_req,
  input  logic [NSRC-1:0] irq_req,
  input  logic [NSRC-1:0] irq_mask,
  input  logic            cpu_m1_n,
  input  logic            cpu_mreq_n,
  input  logic            cpu_iorq_n,
  input  logic            cpu_rd_n,
  input  logic [7:0]      cpu_di,
  output logic            cpu_nmi_n,
  output logic            cpu_int_n,
  output logic [7:0]      vec_data,
  output logic            vec_oe,
  output logic [NSRC-1:0] irq_ack,
  output logic [NSRC-1:0] in_service
);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_DRIVE} ack_state_t;

  logic            r_nmi_s1, r_nmi_s2, r_nmi_s3, r_nmi_pend, r_nmi_n;
  logic            w_nmi_edge, w_nmi_fetch, w_ack_go;
  ack_state_t      r_state;
  logic            r_int_n, r_vec_oe, r_ack_vld;
  logic [7:0]      r_vec_data;
  logic [2:0]      r_ack_idx, w_win_idx;
  logic [NSRC-1:0] r_irq_ack, w_elig, w_ack_dec;
  logic            w_win_vld, w_int_allow;

  assign w_nmi_edge  = r_nmi_s2 & ~r_nmi_s3;
  assign w_nmi_fetch = r_nmi_pend & ~cpu_m1_n & ~cpu_mreq_n;
  // The NMI fake fetch wins over a coincident INTA decode.
  assign w_ack_go    = ~cpu_m1_n & ~cpu_iorq_n & ~w_nmi_fetch;

  // Synchronizer flops reset to 1 so a request held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_nmi_s1   <= 1'b1;
      r_nmi_s2   <= 1'b1;
      r_nmi_s3   <= 1'b1;
      r_nmi_pend <= 1'b0;
      r_nmi_n    <= 1'b1;
    end else begin
      r_nmi_s1 <= nmi_req;
      r_nmi_s2 <= r_nmi_s1;
      r_nmi_s3 <= r_nmi_s2;
      if (w_nmi_fetch) begin
        r_nmi_pend <= 1'b0;
        r_nmi_n    <= 1'b1;
      end else if (w_nmi_edge && !r_nmi_pend) begin
        r_nmi_pend <= 1'b1;
        r_nmi_n    <= 1'b0;
      end
    end
  end

  assign w_elig    = irq_req & ~irq_mask;
  assign w_win_vld = |w_elig;

  always_comb begin
    w_win_idx = 3'd7;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win_idx = 3'(i);
    end
  end

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_ack_dec
    assign w_ack_dec[gi] = r_ack_vld && (r_ack_idx == 3'(gi));
  end

`ifdef Z80_IRQ_RETI_EN
  typedef enum logic {OP_IDLE, OP_ED} op_state_t;

  op_state_t       r_op_state;
  logic [7:0]      r_op;
  logic            r_op_vld, r_m1_d;
  logic            w_op_cap, w_commit, w_reti;
  logic [NSRC-1:0] r_isr, w_isr_low, w_isr_next;

  assign w_op_cap  = ~cpu_m1_n & ~cpu_mreq_n & (~cpu_rd_n | r_nmi_pend);
  assign w_commit  = ~r_m1_d & cpu_m1_n & r_op_vld;
  assign w_reti    = w_commit && (r_op_state == OP_ED) && (r_op == 8'h4D);
  assign w_isr_low = r_isr & (~r_isr + NSRC'(1));

  always_comb begin
    w_isr_next = r_isr;
    if (w_reti) w_isr_next = w_isr_next & ~w_isr_low;
    if (r_state == S_ACK) w_isr_next = w_isr_next | w_ack_dec;
  end

  // A source may interrupt only if its index is below every in-service bit.
  always_comb begin
    logic v_run;
    v_run       = 1'b1;
    w_int_allow = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      v_run = v_run & ~r_isr[i];
      if (v_run && w_elig[i]) w_int_allow = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_state <= OP_IDLE;
      r_op       <= 8'h00;
      r_op_vld   <= 1'b0;
      r_m1_d     <= 1'b1;
      r_isr      <= '0;
    end else begin
      r_m1_d <= cpu_m1_n;
      r_isr  <= w_isr_next;
      if (w_op_cap) begin
        r_op     <= cpu_di;
        r_op_vld <= 1'b1;
      end else if (w_commit) begin
        r_op_vld <= 1'b0;
      end
      // Any committed ED (re)enters OP_ED; everything else falls back to OP_IDLE.
      if (w_commit) r_op_state <= (r_op == 8'hED) ? OP_ED : OP_IDLE;
    end
  end

  assign in_service = r_isr;
`else
  logic w_unused;
  assign w_unused    = ^{cpu_di, cpu_rd_n};
  assign w_int_allow = w_win_vld;
  assign in_service  = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_int_n    <= 1'b1;
      r_vec_oe   <= 1'b0;
      r_vec_data <= 8'h00;
      r_irq_ack  <= '0;
      r_ack_idx  <= 3'd0;
      r_ack_vld  <= 1'b0;
    end else begin
      r_irq_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_ack_go) begin
            r_state   <= S_ACK;
            r_ack_idx <= w_win_idx;
            r_ack_vld <= w_win_vld;
            r_int_n   <= 1'b1;
          end else begin
            r_int_n <= ~w_int_allow;
          end
        end
        S_ACK: begin
          r_state    <= S_DRIVE;
          r_vec_data <= {VEC_BASE[7:4], r_ack_idx, 1'b0};
          r_vec_oe   <= 1'b1;
          r_irq_ack  <= w_ack_dec;
          r_int_n    <= 1'b1;
        end
        S_DRIVE: begin
          r_int_n <= 1'b1;
          if (cpu_iorq_n) begin
            r_state  <= S_IDLE;
            r_vec_oe <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cpu_nmi_n = r_nmi_n;
  assign cpu_int_n = r_int_n;
  assign vec_data  = r_vec_data;
  assign vec_oe    = r_vec_oe;
  assign irq_ack   = r_irq_ack;

endmodule

// File: tb/tb_z80_irq_ctrl.sv
// Directed bench for z80_irq_ctrl (NSRC=4, VEC_BASE=E0); RETI nesting steps run when Z80_IRQ_RETI_EN is defined.
module tb_z80_irq_ctrl;
  logic       clk = 1'b0;
  logic       reset, nmi_req;
  logic [3:0] irq_req, irq_mask;
  logic       cpu_m1_n, cpu_mreq_n, cpu_iorq_n, cpu_rd_n;
  logic [7:0] cpu_di;
  logic       cpu_nmi_n, cpu_int_n, vec_oe;
  logic [7:0] vec_data;
  logic [3:0] irq_ack, in_service;
  logic [3:0] exp_isr;
  int checks = 0;
  int failures = 0;

  z80_irq_ctrl #(.NSRC(4), .VEC_BASE(8'hE0)) dut (
    .clk(clk), .reset(reset), .nmi_req(nmi_req), .irq_req(irq_req), .irq_mask(irq_mask),
    .cpu_m1_n(cpu_m1_n), .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n), .cpu_rd_n(cpu_rd_n),
    .cpu_di(cpu_di), .cpu_nmi_n(cpu_nmi_n), .cpu_int_n(cpu_int_n), .vec_data(vec_data),
    .vec_oe(vec_oe), .irq_ack(irq_ack), .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic bus_idle();
    cpu_m1_n = 1'b1; cpu_mreq_n = 1'b1; cpu_iorq_n = 1'b1; cpu_rd_n = 1'b1;
  endtask

  task automatic fetch(input logic [7:0] op);
    cpu_m1_n = 1'b0; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; cpu_di = op;
    tick();
    bus_idle();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; nmi_req = 1'b0; irq_req = 4'h0; irq_mask = 4'h0; cpu_di = 8'h00;
    bus_idle();
    tick(2);
    reset = 1'b0;
    chk("rst_nmi_n", cpu_nmi_n, 1'b1);
    chk("rst_int_n", cpu_int_n, 1'b1);
    chk("rst_vec_oe", vec_oe, 1'b0);
    chk("rst_vec_data", vec_data, 8'h00);
    chk("rst_irq_ack", irq_ack, 4'h0);
    chk("rst_in_service", in_service, 4'h0);

    // NMI: 3-cycle latency, merge of a second edge, clear on fake fetch
    tick();
    nmi_req = 1'b1;
    tick(); chk("nmi_lat_k", cpu_nmi_n, 1'b1);
    tick(); chk("nmi_lat_k1", cpu_nmi_n, 1'b1);
    tick(); chk("nmi_lat_k2", cpu_nmi_n, 1'b0);
    nmi_req = 1'b0;
    tick();
    nmi_req = 1'b1;
    tick(3); chk("nmi_hold", cpu_nmi_n, 1'b0);
    nmi_req = 1'b0;
    tick(2);
    cpu_m1_n = 1'b0; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; cpu_di = 8'h00;
    tick(); chk("nmi_release", cpu_nmi_n, 1'b1);
    bus_idle();
    tick(5); chk("nmi_merged", cpu_nmi_n, 1'b1);

    // NMI request held high through reset
    nmi_req = 1'b1; reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(5); chk("nmi_thru_reset", cpu_nmi_n, 1'b1);
    nmi_req = 1'b0;
    tick(3);

    // Simultaneous requests 0110, frozen winner when source 0 joins in the ack cycle
    irq_req = 4'b0110;
    chk("int_not_comb", cpu_int_n, 1'b1);
    tick(); chk("int_asserted", cpu_int_n, 1'b0);
    cpu_m1_n = 1'b0; cpu_iorq_n = 1'b0;
    tick(); chk("ack_int_n", cpu_int_n, 1'b1);
    chk("ack_vec_oe0", vec_oe, 1'b0);
    irq_req = 4'b0111;
    tick(); chk("ack_vec_oe1", vec_oe, 1'b1);
    chk("ack_vec_data", vec_data, 8'hE2);
    chk("ack_pulse", irq_ack, 4'b0010);
`ifdef Z80_IRQ_RETI_EN
    exp_isr = 4'b0010;
`else
    exp_isr = 4'b0000;
`endif
    chk("ack_isr", in_service, exp_isr);
    tick(); chk("ack_pulse_end", irq_ack, 4'b0000);
    chk("drive_hold", vec_oe, 1'b1);
    bus_idle();
    tick(); chk("drive_exit", vec_oe, 1'b0);
    tick(); chk("int_reassert", cpu_int_n, 1'b0);

`ifdef Z80_IRQ_RETI_EN
    // Nesting: with source 1 in service, 3 is blocked and 0 gets through
    irq_req = 4'b1010;
    tick(); chk("nest_low_blk", cpu_int_n, 1'b1);
    irq_req = 4'b1011;
    tick(); chk("nest_high_ok", cpu_int_n, 1'b0);
    cpu_m1_n = 1'b0; cpu_iorq_n = 1'b0;
    tick(2); chk("nest_vec", vec_data, 8'hE0);
    chk("nest_isr", in_service, 4'b0011);
    bus_idle(); irq_req = 4'b0000;
    tick();
    fetch(8'hED); fetch(8'h4D);
    chk("reti_first", in_service, 4'b0010);
    fetch(8'h00); fetch(8'h4D);
    chk("reti_not_ed", in_service, 4'b0010);
    fetch(8'hED); fetch(8'h4D);
    chk("reti_second", in_service, 4'b0000);
`endif

    // All sources masked: no INT; forced INTA gives the no-winner vector
    irq_req = 4'b1111; irq_mask = 4'b1111;
    tick(2); chk("mask_int_n", cpu_int_n, 1'b1);
    cpu_m1_n = 1'b0; cpu_iorq_n = 1'b0;
    tick(2); chk("mask_vec", vec_data, 8'hEE);
    chk("mask_oe", vec_oe, 1'b1);
    chk("mask_no_ack", irq_ack, 4'b0000);
    chk("mask_isr", in_service, 4'b0000);
    bus_idle();
    tick(2);

    // Reset while driving the vector
    irq_mask = 4'b0000; irq_req = 4'b0100;
    tick(2);
    cpu_m1_n = 1'b0; cpu_iorq_n = 1'b0;
    tick(2); chk("rdrv_vec", vec_data, 8'hE4);
`ifdef Z80_IRQ_RETI_EN
    exp_isr = 4'b0100;
`else
    exp_isr = 4'b0000;
`endif
    chk("rdrv_isr_pre", in_service, exp_isr);
    reset = 1'b1;
    tick(); chk("rdrv_oe", vec_oe, 1'b0);
    chk("rdrv_isr", in_service, 4'b0000);
    reset = 1'b0; bus_idle(); irq_req = 4'b0000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/z80_irq_ctrl.md
# z80_irq_ctrl

Interrupt front-end for the TV80 core. Turns an asynchronous NMI button and up to `NSRC` level-sensitive peripheral requests into the CPU's `nmi_n` and `int_n` pins. During the IM2 acknowledge cycle it returns a vector byte on the CPU data-in path. It tracks in-service sources by snooping M1 opcode fetches for `RETI`, so interrupts nest by priority.

## Interface
Parameters:
- `NSRC`, 4 — number of maskable sources (1..8); index 0 has the highest priority.
- `VEC_BASE`, 8'hE0 — vector base; bits [3:1] are replaced by the source index, bit 0 is forced to 0.

Ports:
- `clk`  in  1  system clock, shared with the CPU.
- `reset`  in  1  synchronous, active-high reset.
- `nmi_req`  in  1  asynchronous NMI request; the rising edge is the event.
- `irq_req`  in  NSRC  level requests, active-high.
- `irq_mask`  in  NSRC  1 = source disabled.
- `cpu_m1_n`, `cpu_mreq_n`, `cpu_iorq_n`, `cpu_rd_n`  in  1 each  CPU bus strobes.
- `cpu_di`  in  8  byte driven to the CPU (memory read data), snooped for opcodes.
- `cpu_nmi_n`  out  1  to CPU NMI input.
- `cpu_int_n`  out  1  to CPU INT input.
- `vec_data`  out  8  IM2 vector byte.
- `vec_oe`  out  1  1 = data-in mux selects `vec_data`.
- `irq_ack`  out  NSRC  one-cycle pulse on the acknowledged source.
- `in_service`  out  NSRC  in-service register.

## Operation
- **NMI path**
  - `nmi_req` passes through a 2-FF synchronizer, then a rising-edge detector.
  - An edge arms `nmi_pend` and drives `cpu_nmi_n`=0.
  - `nmi_pend` clears on the first clock with `cpu_m1_n`=0 and `cpu_mreq_n`=0 (the NMI fake fetch). `cpu_nmi_n` returns to 1 on the next edge.
  - Edges arriving while `nmi_pend`=1 merge into the pending NMI and are not counted.
- **Maskable path**
  - Eligible set: `elig = irq_req & ~irq_mask`.
  - Winner: lowest set index of `elig`.
  - `cpu_int_n`=0 when the winner exists, its index is lower than every set `in_service` bit, and the controller is in `IDLE`.
- **Acknowledge FSM**, states `IDLE` → `ACK` → `DRIVE` → `IDLE`:
  - `IDLE`→`ACK` on `cpu_m1_n`=0 and `cpu_iorq_n`=0. The winner index is frozen into `ack_idx`; `cpu_int_n` goes to 1.
  - `ACK`→`DRIVE` unconditionally. In this transition: `vec_data = VEC_BASE[7:4],ack_idx[2:0],1'b0`; `vec_oe`=1; `irq_ack[ack_idx]` pulses for one cycle; `in_service[ack_idx]` is set.
  - `DRIVE`→`IDLE` when `cpu_iorq_n`=1; `vec_oe` drops at the same time.
  - If no winner exists at the ack strobe, `ack_idx`=7 and no `irq_ack`/`in_service` update occurs. The vector is still driven.
- **RETI snoop**, states `OP_IDLE`, `OP_ED`:
  - An opcode is `cpu_di` captured on the last clock with `cpu_m1_n`=`cpu_mreq_n`=`cpu_rd_n`=0. It is committed when `cpu_m1_n` rises.
  - In `OP_IDLE`, a committed ED moves to `OP_ED`.
  - In `OP_ED`, a committed 4D clears the lowest-index set `in_service` bit and returns to `OP_IDLE`. Any other opcode returns to `OP_IDLE`, or stays in `OP_ED` if it is ED.
  - The NMI fake fetch also advances the snoop with whatever `cpu_di` carries.
- **Reset values**
  - `cpu_nmi_n`=1, `cpu_int_n`=1, `vec_oe`=0, `vec_data`=8'h00, `irq_ack`=0, `in_service`=0.
  - FSMs go to `IDLE`/`OP_IDLE`.
  - The synchronizer flops load 1, so an `nmi_req` held high through reset never produces an NMI.
  - Reset during `DRIVE` drops `vec_oe` on the next edge.

## Timing
- NMI: `nmi_req` rising before edge k gives `cpu_nmi_n`=0 after edge k+2 (3-cycle latency).
- INT: a change in `elig`, `irq_mask` or `in_service` is reflected on `cpu_int_n` one clock later (registered).
- Ack: the strobe sampled at edge k gives `vec_oe`=1 after k+1. `irq_ack` is high only in the cycle following edge k+1.
- Simultaneous ack strobe and NMI fake fetch cannot occur. If both are decoded in the same cycle, NMI clearing has priority and the ack strobe is ignored.
- A new request arriving in the ack cycle does not change the frozen `ack_idx`.

## Configuration
- `Z80_IRQ_RETI_EN` defined:
  - RETI snoop is present.
  - `in_service` clears only on RETI.
  - Only strictly higher-priority sources can interrupt an in-service one.
- Not defined:
  - Snoop logic is omitted.
  - `in_service` is constant 0.
  - `cpu_int_n` depends only on `elig` and the FSM state.
  - `cpu_di` is unused.

## Test plan
- **NMI after reset:** reset, then pulse `nmi_req`. `cpu_nmi_n`=0 three cycles later and stays 0 until M1+MREQ is low, then returns to 1 one cycle later. With the CPU connected (SP=0000), the core reaches PC=0066 and SP=FFFE.
- **NMI held through reset:** `nmi_req` held high across reset → `cpu_nmi_n` stays 1.
- **Simultaneous requests:** `irq_req`=4'b0110, mask 0, INTA cycle → `vec_data`=8'hE2, `irq_ack`=4'b0010, `in_service`=4'b0010.
- **Nesting (with `Z80_IRQ_RETI_EN`):**
  - With source 1 in service: raising source 3 leaves `cpu_int_n`=1; raising source 0 drives `cpu_int_n`=0.
  - Fetching ED,4D clears bit 0 first, then bit 1.
- **Mask and no winner:** `irq_mask`=4'b1111 with all requests set → `cpu_int_n` stays 1. A forced INTA strobe yields `vec_data`=8'hEE and no ack pulse.
- **Reset during `DRIVE`:** `vec_oe` drops after one edge and `in_service` becomes 0.
